// File: rtl/vx_dispatchv_lane_serializer_pkg.sv
// Shared sizing helpers, FSM state type and beat flag struct for the
// dispatch-vector lane serializer.
package vx_dispatchv_lane_serializer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSerial
    } ser_state_e;

    typedef struct packed {
        logic sop;
        logic eop;
    } beat_flags_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned calc_nbeats(input int unsigned threads,
                                                input int unsigned lanes);
        return threads / lanes;
    endfunction

    function automatic int unsigned calc_pid_w(input int unsigned nbeats);
        return clog2_min1(nbeats);
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_dispatchv_beat_sel.sv
// Priority encoder over a remaining-active beat mask: lowest set index,
// the mask with that bit cleared, and whether it was the last one.
module vx_dispatchv_beat_sel
    import vx_dispatchv_lane_serializer_pkg::*;
#(
    parameter int unsigned NBEATS = 4,
    parameter int unsigned PID_W  = calc_pid_w(NBEATS)
) (
    input  logic [NBEATS-1:0] i_mask,
    output logic [PID_W-1:0]  o_idx,
    output logic [NBEATS-1:0] o_rem,
    output logic              o_last
);

    logic w_found;

    // An all-zero mask yields index 0 with last set.
    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NBEATS; i++) begin
            if (!w_found && i_mask[i]) begin
                o_idx   = PID_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign o_rem  = i_mask & (i_mask - NBEATS'(1));
    assign o_last = (o_rem == '0);

endmodule

// File: rtl/vx_dispatchv_lane_serializer.sv
// Buffers full-width vector dispatch packets and re-issues each as
// NUM_LANES-wide beats, skipping beats with an all-zero mask slice.
module vx_dispatchv_lane_serializer
    import vx_dispatchv_lane_serializer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HDR_W       = 64,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned NBEATS     = calc_nbeats(NUM_THREADS, NUM_LANES),
    localparam int unsigned PID_W      = calc_pid_w(NBEATS),
    localparam int unsigned CNT_W      = calc_cnt_w(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [HDR_W-1:0]            in_hdr,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [HDR_W-1:0]            out_hdr,
    output logic [NUM_LANES-1:0]        out_tmask,
    output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
    output logic [PID_W-1:0]            out_pid,
    output logic                        out_sop,
    output logic                        out_eop,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            count
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned LW    = NUM_LANES * XLEN;

    typedef struct packed {
        logic [HDR_W-1:0]     hdr;
        logic [NUM_LANES-1:0] tmask;
        logic [LW-1:0]        rs1;
        logic [LW-1:0]        rs2;
        logic [LW-1:0]        rs3;
        logic [PID_W-1:0]     pid;
        beat_flags_t          flags;
    } beat_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [HDR_W-1:0]            r_hdr_mem   [DEPTH];
    logic [NUM_THREADS-1:0]      r_tmask_mem [DEPTH];
    logic [NUM_THREADS*XLEN-1:0] r_rs1_mem   [DEPTH];
    logic [NUM_THREADS*XLEN-1:0] r_rs2_mem   [DEPTH];
    logic [NUM_THREADS*XLEN-1:0] r_rs3_mem   [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    ser_state_e        r_state, w_state_nxt;
    logic [PID_W-1:0]  r_pid, w_pid_nxt;
    logic [NBEATS-1:0] r_rem, w_rem_nxt;
    logic              r_sop, w_sop_nxt;
    logic              r_eop, w_eop_nxt;

    logic              w_push, w_fire, w_pop, w_ld_from_mem;
    logic [PTR_W-1:0]  w_rd_ptr_inc;
    logic [NBEATS-1:0] w_in_act, w_mem_act, w_ld_mask;
    logic [PID_W-1:0]  w_first_idx, w_next_idx;
    logic [NBEATS-1:0] w_first_rem, w_next_rem;
    logic              w_first_last, w_next_last;
    beat_t             w_beat;

    assign in_ready     = (r_count < CNT_W'(DEPTH)) && !flush;
    assign out_valid    = (r_state == StSerial);
    assign count        = r_count;
    assign w_push       = in_valid && in_ready;
    assign w_fire       = out_valid && out_ready;
    assign w_pop        = w_fire && r_eop;
    assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);

    for (genvar b = 0; b < NBEATS; b++) begin : g_act
        assign w_in_act[b]  = |in_tmask[b*NUM_LANES +: NUM_LANES];
        assign w_mem_act[b] = |r_tmask_mem[w_rd_ptr_inc][b*NUM_LANES +: NUM_LANES];
    end

    // The next head comes from storage unless the FIFO is about to hold only
    // the packet being pushed this cycle, which has not been written yet.
    assign w_ld_from_mem = (r_state == StSerial) && (r_count > CNT_W'(1));
    assign w_ld_mask     = w_ld_from_mem ? w_mem_act : w_in_act;

    vx_dispatchv_beat_sel #(
        .NBEATS(NBEATS),
        .PID_W (PID_W)
    ) u_first_sel (
        .i_mask(w_ld_mask),
        .o_idx (w_first_idx),
        .o_rem (w_first_rem),
        .o_last(w_first_last)
    );

    vx_dispatchv_beat_sel #(
        .NBEATS(NBEATS),
        .PID_W (PID_W)
    ) u_next_sel (
        .i_mask(r_rem),
        .o_idx (w_next_idx),
        .o_rem (w_next_rem),
        .o_last(w_next_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pid_nxt   = r_pid;
        w_rem_nxt   = r_rem;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        case (r_state)
            StIdle: begin
                if (w_push) begin
                    w_state_nxt = StSerial;
                    w_pid_nxt   = w_first_idx;
                    w_rem_nxt   = w_first_rem;
                    w_sop_nxt   = 1'b1;
                    w_eop_nxt   = w_first_last;
                end
            end
            StSerial: begin
                if (w_fire && !r_eop) begin
                    w_pid_nxt = w_next_idx;
                    w_rem_nxt = w_next_rem;
                    w_sop_nxt = 1'b0;
                    w_eop_nxt = w_next_last;
                end else if (w_fire && (r_count > CNT_W'(1) || w_push)) begin
                    w_pid_nxt = w_first_idx;
                    w_rem_nxt = w_first_rem;
                    w_sop_nxt = 1'b1;
                    w_eop_nxt = w_first_last;
                end else if (w_fire) begin
                    w_state_nxt = StIdle;
                    w_pid_nxt   = '0;
                    w_rem_nxt   = '0;
                    w_sop_nxt   = 1'b0;
                    w_eop_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (flush) begin
            w_state_nxt = StIdle;
            w_pid_nxt   = '0;
            w_rem_nxt   = '0;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_pid   <= '0;
            r_rem   <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pid   <= w_pid_nxt;
            r_rem   <= w_rem_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hdr_mem[r_wr_ptr]   <= in_hdr;
            r_tmask_mem[r_wr_ptr] <= in_tmask;
            r_rs1_mem[r_wr_ptr]   <= in_rs1_data;
            r_rs2_mem[r_wr_ptr]   <= in_rs2_data;
            r_rs3_mem[r_wr_ptr]   <= in_rs3_data;
        end
    end

    // Head slot is never the write target while serializing, so the beat
    // holds stable under backpressure.
    always_comb begin
        w_beat.hdr       = r_hdr_mem[r_rd_ptr];
        w_beat.tmask     = r_tmask_mem[r_rd_ptr][r_pid*NUM_LANES +: NUM_LANES];
        w_beat.rs1       = r_rs1_mem[r_rd_ptr][r_pid*LW +: LW];
        w_beat.rs2       = r_rs2_mem[r_rd_ptr][r_pid*LW +: LW];
        w_beat.rs3       = r_rs3_mem[r_rd_ptr][r_pid*LW +: LW];
        w_beat.pid       = r_pid;
        w_beat.flags.sop = r_sop;
        w_beat.flags.eop = r_eop;
    end

    assign out_hdr      = w_beat.hdr;
    assign out_tmask    = w_beat.tmask;
    assign out_rs1_data = w_beat.rs1;
    assign out_rs2_data = w_beat.rs2;
    assign out_rs3_data = w_beat.rs3;
    assign out_pid      = w_beat.pid;
    assign out_sop      = w_beat.flags.sop;
    assign out_eop      = w_beat.flags.eop;

endmodule

// File: tb/tb_vx_dispatchv_lane_serializer.sv
// Scoreboard bench: accepted packets expand into expected beat lists; a
// negedge monitor compares every presented beat and the count/ready/valid.
module tb_vx_dispatchv_lane_serializer;

    localparam int NT = 8;
    localparam int NL = 2;
    localparam int XL = 32;
    localparam int HW = 64;
    localparam int DP = 4;
    localparam int NB = NT / NL;
    localparam int PW = 2;
    localparam int CW = 3;

    typedef struct packed {
        logic [HW-1:0]    hdr;
        logic [NL-1:0]    tm;
        logic [NL*XL-1:0] r1;
        logic [NL*XL-1:0] r2;
        logic [NL*XL-1:0] r3;
        logic [PW-1:0]    pid;
        logic             sop;
        logic             eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, out_valid, out_sop, out_eop, out_ready;
    logic [HW-1:0]    in_hdr, out_hdr;
    logic [NT-1:0]    in_tmask;
    logic [NT*XL-1:0] in_rs1_data, in_rs2_data, in_rs3_data;
    logic [NL-1:0]    out_tmask;
    logic [NL*XL-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
    logic [PW-1:0]    out_pid;
    logic [CW-1:0]    count;

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    m_count = 0;
    bit    rand_on;

    always #5 clk = ~clk;

    vx_dispatchv_lane_serializer #(
        .NUM_THREADS(NT),
        .NUM_LANES  (NL),
        .XLEN       (XL),
        .HDR_W      (HW),
        .DEPTH      (DP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_hdr      (in_hdr),
        .in_tmask    (in_tmask),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_rs3_data (in_rs3_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_hdr     (out_hdr),
        .out_tmask   (out_tmask),
        .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data),
        .out_rs3_data(out_rs3_data),
        .out_pid     (out_pid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_ready   (out_ready),
        .count       (count)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list the active beat indices, one beat per index.
    int    act_idx[$];
    beat_t eb;
    bit    m_ready;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            m_ready = (m_count < DP) && !flush;
            chk("count", 512'(count), 512'(m_count));
            chk("in_ready", 512'(in_ready), 512'(m_ready));
            chk("out_valid", 512'(out_valid), 512'(m_count != 0));
            if (flush) begin
                exp_q.delete();
                m_count = 0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 512'(out_valid), 512'(0));
                    end else begin
                        chk("beat", 512'({out_hdr, out_tmask, out_rs1_data, out_rs2_data,
                                          out_rs3_data, out_pid, out_sop, out_eop}),
                            512'(exp_q[0]));
                        if (out_ready) begin
                            if (exp_q[0].eop) m_count--;
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (in_valid && m_ready) begin
                    act_idx.delete();
                    for (int b = 0; b < NB; b++)
                        if (in_tmask[b*NL +: NL] != '0) act_idx.push_back(b);
                    if (act_idx.size() == 0) act_idx.push_back(0);
                    for (int k = 0; k < act_idx.size(); k++) begin
                        eb.hdr = in_hdr;
                        eb.tm  = in_tmask[act_idx[k]*NL +: NL];
                        eb.r1  = in_rs1_data[act_idx[k]*NL*XL +: NL*XL];
                        eb.r2  = in_rs2_data[act_idx[k]*NL*XL +: NL*XL];
                        eb.r3  = in_rs3_data[act_idx[k]*NL*XL +: NL*XL];
                        eb.pid = PW'(act_idx[k]);
                        eb.sop = (k == 0);
                        eb.eop = (k == act_idx.size() - 1);
                        exp_q.push_back(eb);
                    end
                    m_count++;
                end
            end
        end
    end

    task automatic load_pkt(input logic [NT-1:0] tm);
        in_hdr   = {$urandom, $urandom};
        in_tmask = tm;
        for (int t = 0; t < NT; t++) begin
            in_rs1_data[t*XL +: XL] = $urandom;
            in_rs2_data[t*XL +: XL] = $urandom;
            in_rs3_data[t*XL +: XL] = $urandom;
        end
    endtask

    task automatic offer(input logic [NT-1:0] tm);
        load_pkt(tm);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [NT-1:0] tm);
        bit acc = 1'b0;
        load_pkt(tm);
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept", 512'(acc), 512'(1));
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        chk("drain", 512'(done), 512'(1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NT-1:0] rand_mask();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return NT'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        load_pkt('0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_count", 512'(count), 512'(0));
        chk("rst_pid", 512'(out_pid), 512'(0));
        chk("rst_sop", 512'(out_sop), 512'(0));
        chk("rst_eop", 512'(out_eop), 512'(0));
        @(posedge clk);
        #1 reset = 1'b1;

        out_ready = 1'b1;
        send(8'hFF); drain();
        send(8'b0011_0000); drain();
        send(8'h00); drain();

        // Stall on pid 1 for three cycles.
        send(8'hFF);
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_pid", 512'(out_pid), 512'(1));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Fill with five offers; only four fit.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) offer(rand_mask());
        @(negedge clk);
        chk("full_count", 512'(count), 512'(DP));
        chk("full_in_ready", 512'(in_ready), 512'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Flush with a simultaneous offer that must be dropped.
        out_ready = 1'b0;
        send(8'hFF); send(8'h3C);
        load_pkt(8'hFF);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_count", 512'(count), 512'(0));
        chk("flush_valid", 512'(out_valid), 512'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'hA5); drain();

        // Asynchronous reset mid-packet with a full FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < DP; i++) send(8'hFF);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("prerst_pid", 512'(out_pid), 512'(1));
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 512'(out_valid), 512'(0));
        chk("async_rst_count", 512'(count), 512'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        send(8'h0C); drain();

        // Randomized traffic with random backpressure.
        rand_on = 1'b1;
        fork
            begin
                for (int p = 0; p < 300; p++) begin
                    send(rand_mask());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
